// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and helpers for the UART receive path: receiver
//               state encoding, parity mode constants and the baud divisor
//               calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states, explicitly encoded.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PAR       = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Parity mode selectors.
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int calc_div(input longint clk_hz, input longint baud,
                                    input longint os);
        longint w_den;
        longint w_q;
        w_den = baud * os;
        w_q   = (clk_hz + w_den / 2) / w_den;
        if (w_q < 1) begin
            w_q = 1;
        end
        return int'(w_q);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead read data. A pop while
//               empty is ignored; a push while full is dropped unless a pop
//               in the same cycle frees a slot.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               push, push_data - write request and data
//               pop             - read request (advances head)
//               rd_data         - head entry, 0 while empty
//               full, empty     - occupancy flags
//               count           - entries held (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL_COUNT = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL_COUNT);
    assign w_do_pop  = pop && !empty;
    // A simultaneous pop makes room, so a push on a full FIFO still lands.
    assign w_do_push = push && (!full || w_do_pop);

    assign count   = r_count;
    // Forced to zero while empty so stale or unwritten storage never shows.
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    // Storage is not reset; it is only visible through rd_data when valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Oversampling UART receiver feeding a show-ahead receive FIFO,
//               with sticky frame, parity and overrun error flags.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               rx           - asynchronous serial input, idle high
//               rd_en        - pop the FIFO head
//               rd_data      - FIFO head (valid while rd_valid)
//               rd_valid     - FIFO non-empty
//               count        - entries held
//               err_clr      - clear all sticky error flags
//               frame_err    - stop bit sampled low
//               parity_err   - parity mismatch
//               overrun_err  - frame completed while FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    input  logic                          err_clr,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun_err
);

    localparam int c_DIV   = calc_div(longint'(CLK_FREQ_HZ), longint'(BAUD),
                                      longint'(OVERSAMPLE));
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OS_W  = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(DATA_BITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
    localparam logic [c_OS_W-1:0]  c_OS_HALF  = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Input synchroniser; resets to the idle line level.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rxs   <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver datapath and FSM
    // ------------------------------------------------------------------
    rx_state_t              r_state;
    logic [c_DIV_W-1:0]     r_div_cnt;
    logic [c_OS_W-1:0]      r_os_cnt;
    logic [c_BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_par_bad;

    logic                   w_tick;
    logic [c_OS_W-1:0]      w_os_target;
    logic                   w_sample;
    logic                   w_par_exp;
    logic                   w_stop_sample;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;

    // Divider idles at zero in IDLE, which doubles as the reload on START entry.
    assign w_tick      = (r_state != ST_IDLE) && (r_div_cnt == c_DIV_LAST);
    // The start bit is checked half a bit in so later samples land mid-bit.
    assign w_os_target = (r_state == ST_START) ? c_OS_HALF : c_OS_LAST;
    assign w_sample    = w_tick && (r_os_cnt == w_os_target);
    assign w_par_exp   = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);

    assign w_stop_sample = w_sample && (r_state == ST_STOP);
    // Push goes straight into the FIFO on the stop sample edge.
    assign w_push        = w_stop_sample && r_rxs && !r_par_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div_cnt <= '0;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_bad <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) || w_tick) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end

            if ((r_state == ST_IDLE) || w_sample) begin
                r_os_cnt <= '0;
            end else if (w_tick) begin
                r_os_cnt <= r_os_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_rxs) begin
                        r_state   <= ST_START;
                        r_bit_cnt <= '0;
                        r_par_bad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_sample) begin
                        // Line back high by mid-start: treat as a glitch.
                        r_state <= r_rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_sample) begin
                        r_par_bad <= (r_rxs != w_par_exp);
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        // A low stop bit may be a break; wait for the line to
                        // recover rather than retriggering on it.
                        r_state <= r_rxs ? ST_IDLE : ST_WAIT_HIGH;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (r_rxs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags; a set event wins over a simultaneous clear.
    // ------------------------------------------------------------------
    logic r_frame_err;
    logic r_parity_err;
    logic r_overrun_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err   <= 1'b0;
            r_parity_err  <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_stop_sample && !r_rxs) begin
                r_frame_err <= 1'b1;
            end else if (err_clr) begin
                r_frame_err <= 1'b0;
            end

            if (w_stop_sample && r_rxs && r_par_bad) begin
                r_parity_err <= 1'b1;
            end else if (err_clr) begin
                r_parity_err <= 1'b0;
            end

            // A concurrent pop frees a slot, so only an unrelieved full is an overrun.
            if (w_push && w_full && !rd_en) begin
                r_overrun_err <= 1'b1;
            end else if (err_clr) begin
                r_overrun_err <= 1'b0;
            end
        end
    end

    assign frame_err   = r_frame_err;
    assign parity_err  = r_parity_err;
    assign overrun_err = r_overrun_err;

    // ------------------------------------------------------------------
    // Receive buffer
    // ------------------------------------------------------------------
    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (r_shift),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (count)
    );

    assign rd_valid = !w_empty;

endmodule
`default_nettype wire
